// File: rtl/traffic_light_pkg.sv
// Shared types and helpers for the N-phase traffic-light controller.
// Phase count is capped at 8, so the helpers work on 8-bit vectors.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        GREEN,
        YELLOW,
        ARED,
        FLASH
    } state_e;

    localparam int LAMP_R = 2;
    localparam int LAMP_Y = 1;
    localparam int LAMP_G = 0;
    localparam int MAX_PHASE = 8;

    // Nearest pending phase after ph, wrapping; ph itself is the last
    // candidate. With nothing pending the result is ph+1 mod n.
    function automatic logic [2:0] rr_next(
        input logic [7:0] pend,
        input logic [2:0] ph,
        input int         n
    );
        int         idx;
        logic [2:0] r;
        r = 3'((int'(ph) + 1) % n);
        for (int k = MAX_PHASE; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(ph) + k) % n;
                if (pend[idx]) r = 3'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_light_multi_tick_gen.sv
// Seconds prescaler: one-cycle tick every CLK_DIV clocks.
// clr restarts the count so every interval begins on a fresh second.
module tick_gen #(
    parameter int CLK_DIV = 125000000
) (
    input  logic clk_125M,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_light_multi.sv
// N-phase round-robin traffic-light controller with min/max green,
// yellow, all-red clearance and emergency flash; outputs registered.
module traffic_light_multi
    import traffic_light_pkg::*;
#(
    parameter int N_PHASE = 4,
    parameter int CLK_DIV = 125000000,
    parameter int T_GMIN  = 10,
    parameter int T_GMAX  = 40,
    parameter int T_YEL   = 3,
    parameter int T_ARED  = 1,
    parameter int T_W     = 8,
    localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1
) (
    input  logic                   clk_125M,
    input  logic                   rst,
    input  logic [N_PHASE-1:0]     req,
    input  logic                   flash,
    output logic [3*N_PHASE-1:0]   lamp,
    output logic [PW-1:0]          phase,
    output logic [T_W-1:0]         remain_s,
    output logic                   busy_flash
);

    localparam logic [T_W-1:0] GMIN_M1 = T_W'(T_GMIN - 1);
    localparam logic [T_W-1:0] GMAX_M1 = T_W'(T_GMAX - 1);
    localparam logic [T_W-1:0] YEL_M1  = T_W'(T_YEL - 1);
    localparam logic [T_W-1:0] ARED_M1 = T_W'(T_ARED - 1);

    state_e                 state_q, state_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [PW-1:0]          nxt_q, nxt_d;
    logic [N_PHASE-1:0]     pend_q, pend_d;
    logic [T_W-1:0]         sec_q, sec_d;
    logic                   fon_q, fon_d;
    logic [3*N_PHASE-1:0]   lamp_q, lamp_d;
    logic [T_W-1:0]         rem_q, rem_d;
    logic                   busy_q, busy_d;
    logic [N_PHASE-1:0]     other_q, other_d;
    logic                   tick, clr;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_125M (clk_125M),
        .rst      (rst),
        .clr      (clr),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        nxt_d   = nxt_q;
        sec_d   = sec_q;
        fon_d   = fon_q;
        pend_d  = pend_q | req;
        other_q = pend_q & ~(N_PHASE'(1) << phase_q);

        unique case (state_q)
            GREEN: if (tick) begin
                if (sec_q < GMAX_M1) sec_d = sec_q + T_W'(1);
                if (|other_q && ((sec_q >= GMIN_M1 && !req[phase_q])
                                 || sec_q == GMAX_M1)) begin
                    state_d = YELLOW;
                    nxt_d   = PW'(rr_next(8'(pend_q), 3'(phase_q), N_PHASE));
                end
            end
            YELLOW: if (tick) begin
                if (sec_q == YEL_M1) state_d = ARED;
                else sec_d = sec_q + T_W'(1);
            end
            ARED: if (tick) begin
                if (sec_q == ARED_M1) begin
                    state_d = GREEN;
                    phase_d = nxt_q;
                end else begin
                    sec_d = sec_q + T_W'(1);
                end
            end
            FLASH: begin
                if (tick) fon_d = ~fon_q;
                if (!flash) begin
                    state_d = ARED;
                    nxt_d   = PW'(rr_next(8'(pend_q), 3'(phase_q), N_PHASE));
                end
            end
        endcase

        // Flash overrides any expiry decided above.
        if (flash) begin
            state_d = FLASH;
            phase_d = phase_q;
            nxt_d   = nxt_q;
        end

        clr = (state_d != state_q);
        if (clr) begin
            sec_d = '0;
            if (state_d == FLASH) fon_d = 1'b1;
            if (state_d == GREEN) pend_d[phase_d] = 1'b0;
        end

        lamp_d = '0;
        for (int p = 0; p < N_PHASE; p++) begin
            unique case (state_d)
                GREEN:  lamp_d[3*p + ((p == int'(phase_d)) ? LAMP_G : LAMP_R)] = 1'b1;
                YELLOW: lamp_d[3*p + ((p == int'(phase_d)) ? LAMP_Y : LAMP_R)] = 1'b1;
                ARED:   lamp_d[3*p + LAMP_R] = 1'b1;
                FLASH:  lamp_d[3*p + LAMP_Y] = fon_d;
            endcase
        end

        other_d = pend_d & ~(N_PHASE'(1) << phase_d);
        rem_d   = '0;
        unique case (state_d)
            GREEN:  if (|other_d) rem_d = T_W'(T_GMAX) - sec_d;
            YELLOW: rem_d = T_W'(T_YEL) - sec_d;
            ARED:   rem_d = T_W'(T_ARED) - sec_d;
            FLASH:  rem_d = '0;
        endcase
        busy_d = (state_d == FLASH);
    end

    always_ff @(posedge clk_125M or negedge rst) begin
        if (!rst) begin
            state_q <= ARED;
            phase_q <= PW'(N_PHASE - 1);
            nxt_q   <= '0;
            pend_q  <= '0;
            sec_q   <= '0;
            fon_q   <= 1'b0;
            lamp_q  <= {N_PHASE{3'b100}};
            rem_q   <= T_W'(T_ARED);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            nxt_q   <= nxt_d;
            pend_q  <= pend_d;
            sec_q   <= sec_d;
            fon_q   <= fon_d;
            lamp_q  <= lamp_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
        end
    end

    assign lamp       = lamp_q;
    assign phase      = phase_q;
    assign remain_s   = rem_q;
    assign busy_flash = busy_q;

endmodule

// File: doc/traffic_light_multi.md
Name: traffic_light_multi

Overview:
Parametrised N-phase traffic-light controller, successor to the 2-road highway/farm-road controller.
- Round-robin phase sequencing driven by per-phase vehicle requests.
- Minimum and maximum green times, plus yellow and all-red clearance intervals.
- Emergency flash mode.
- Integrated seconds prescaler and interval timer, so there is no separate divided clock; everything runs on clk_125M.
- Sits at the intersection top level and drives lamp outputs directly.

Parameters:
N_PHASE, 4, number of phases (2..8)
CLK_DIV, 125000000, clk_125M cycles per 1 s tick
T_GMIN, 10, minimum green, in s
T_GMAX, 40, maximum green when other phases are waiting, in s
T_YEL, 3, yellow time, in s
T_ARED, 1, all-red clearance, in s
T_W, 8, width of the seconds counter and remain_s; must hold max(T_*)

Ports:
clk_125M  in  1  system clock; the only clock
rst  in  1  asynchronous reset, active-low
req  in  N_PHASE  per-phase vehicle sensor; level or pulse
flash  in  1  emergency/maintenance flash request, level
lamp  out  3*N_PHASE  per phase p: bits [3p+2:3p] = {R,Y,G}
phase  out  $clog2(N_PHASE)  index of the current/last served phase
remain_s  out  T_W  seconds left in the current timed interval; 0 when resting
busy_flash  out  1  high while in FLASH

Behaviour:
- Reset (rst low, asynchronous): state=ARED, phase=N_PHASE-1, pending=0, sec_cnt=0, prescaler=0, all lamps R only (lamp = {N_PHASE{3'b100}}), remain_s=T_ARED, busy_flash=0. First green after release is phase 0.
- Prescaler: counts 0..CLK_DIV-1. tick is a 1-cycle pulse at CLK_DIV-1. Prescaler and sec_cnt are cleared on every state entry, so each interval lasts exactly T*CLK_DIV cycles.
- Interval timing: on tick, if sec_cnt==T_state-1 the interval expires, otherwise sec_cnt++. In GREEN, sec_cnt saturates at T_GMAX-1.
- Request latching: pending[i] is set by req[i]. pending[phase] is cleared on GREEN entry. A req that is high on the GREEN-entry cycle for the same phase stays served, not pending.
- Next-phase select: round-robin search of pending from phase+1, wrapping. With no pending bits, nxt=phase+1 mod N_PHASE.
- States (all outputs registered; lamps change 1 cycle after the deciding edge):
  - GREEN: lamp[phase]=G, others R.
    - Leave for YELLOW when another phase is pending AND either (sec_cnt>=T_GMIN-1 on tick, and req[phase]==0) or (GMAX expiry on tick).
    - With no other phase pending, rest in GREEN indefinitely; remain_s=0.
  - YELLOW: lamp[phase]=Y, others R. nxt is latched on entry. On expiry go to ARED.
  - ARED: all R. On expiry, phase<=latched nxt and go to GREEN.
  - FLASH: every phase shows Y on odd seconds and all dark on even seconds. Toggle on each tick, starting lit. busy_flash=1.
- flash handling:
  - flash=1 preempts any state on the next edge and goes to FLASH; pending is retained.
  - On flash=0, go to ARED (full T_ARED), then green on the round-robin pick.
- remain_s = T_state - sec_cnt in YELLOW/ARED, and in GREEN while other phases are pending (measured against T_GMAX). Otherwise 0.
- Safety invariant: at most one phase has G or Y at any time, except the all-Y FLASH display. Never G on two phases.
- Simultaneous events: req changing on the decision edge is sampled into pending; the decision uses pending before update. flash wins over any expiry.
- Reset mid-interval returns immediately to the reset state.

Decomposition:
- Package traffic_light_pkg:
  - state enum {GREEN, YELLOW, ARED, FLASH}
  - lamp bit index constants LAMP_R=2, LAMP_Y=1, LAMP_G=0
  - round-robin priority function rr_next(pending, phase)
- Sub-module tick_gen (parameter CLK_DIV): inputs clk_125M, rst, clr; output tick.

Test Plan:
(Parameters for all scenarios: N_PHASE=4, CLK_DIV=4, T_GMIN=2, T_GMAX=5, T_YEL=2, T_ARED=1.)
- Reset then no req -> ARED for 4 cycles, then phase 0 green and rests there; remain_s=0; lamp=12'b100_100_100_001.
- Phase 0 green, req[2] pulse at sec 0, req[0]=0 -> yellow after 8 cycles of green, yellow for 8, all-red for 4, then phase 2 green; pending[2] cleared.
- req[0] held high, req[1] and req[3] pending -> phase 0 green exactly 20 cycles (GMAX), then phase 1 served, then phase 3, skipping 2.
- flash asserted mid-YELLOW -> next cycle all lamps Y, busy_flash=1, dark after 4 cycles; deassert -> all-red 4 cycles, then green on the pending round-robin pick.
- rst low mid-GREEN of phase 2 -> lamps all R asynchronously; after release, phase 0 is green after 4 cycles.
- Continuous checker over all runs: never two phases with G, and never G adjacent to Y-to-G without an intervening ARED.
